// File: rtl/mips_ctrl_pkg.sv
// Shared encodings and the state enum for the multicycle MIPS control FSM.
// MIPS_JUMP_EN adds the JEX state and accepts J (Op 000010).
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
  localparam logic [1:0] PCSRC_JUMP      = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BEQEX,
    S_ADDIEX,
    S_ADDIWB
`ifdef MIPS_JUMP_EN
    , S_JEX
`endif
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// R-type Funct to ALUControl mapping; valid flags the supported Funct codes.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       valid
);

  always_comb begin
    // NOTE: every output is given a default before the case so no path infers a latch.
    alu_control = ALU_ADD;
    valid       = 1'b1;
    case (funct)
      FUNCT_ADD: alu_control = ALU_ADD;
      FUNCT_SUB: alu_control = ALU_SUB;
      FUNCT_AND: alu_control = ALU_AND;
      FUNCT_OR:  alu_control = ALU_OR;
      FUNCT_SLT: alu_control = ALU_SLT;
      default:   valid       = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control sequencer: Moore FSM with MemReady-gated memory states.
// Define MIPS_JUMP_EN to enable the J instruction (JEX state).
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       InstrDone,
  output logic       Illegal
);

  state_t     state, state_next;
  logic [3:0] rtype_alu;
  logic       funct_valid;
  logic       mem_write, ir_write, pc_write, branch, reg_write, done, illegal;

  alu_decoder u_alu_decoder (
    .funct       (Funct),
    .alu_control (rtype_alu),
    .valid       (funct_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking so the state flop samples only pre-edge values.
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    IorD       = 1'b0;
    PCSrc      = PCSRC_ALURESULT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_B;
    ALUControl = ALU_AND;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB    = SRCB_FOUR;
        ALUControl = ALU_ADD;
        ir_write   = MemReady;
        pc_write   = MemReady;
        state_next = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB    = SRCB_IMM_SH2;
        ALUControl = ALU_ADD;
        case (Op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE: begin
            state_next = funct_valid ? S_EXECUTE : S_FETCH;
            illegal    = ~funct_valid;
          end
          OP_BEQ:  state_next = S_BEQEX;
          OP_ADDI: state_next = S_ADDIEX;
`ifdef MIPS_JUMP_EN
          OP_J:    state_next = S_JEX;
`endif
          default: begin
            state_next = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = ALU_ADD;
        state_next = (Op == OP_LW) ? S_MEMRD : (Op == OP_SW) ? S_MEMWR : S_FETCH;
      end
      S_MEMRD: begin
        IorD       = 1'b1;
        state_next = MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        reg_write  = 1'b1;
        done       = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        mem_write  = 1'b1;
        done       = MemReady;
        state_next = MemReady ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = rtype_alu;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        reg_write  = 1'b1;
        done       = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQEX: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = PCSRC_ALUOUT;
        branch     = 1'b1;
        done       = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = ALU_ADD;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        done       = 1'b1;
        state_next = S_FETCH;
      end
`ifdef MIPS_JUMP_EN
      S_JEX: begin
        PCSrc      = PCSRC_JUMP;
        pc_write   = 1'b1;
        done       = 1'b1;
        state_next = S_FETCH;
      end
`endif
      default: state_next = S_FETCH;
    endcase
  end

  // Strobes are masked by reset so a pending write is dropped the instant reset rises.
  assign MemWrite  = mem_write & ~reset;
  assign IRWrite   = ir_write  & ~reset;
  assign PCEn      = (pc_write | (branch & Zero)) & ~reset;
  assign RegWrite  = reg_write & ~reset;
  assign InstrDone = done      & ~reset;
  assign Illegal   = illegal   & ~reset;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-cycle expected control words
// are queued by the driver and compared by a negedge monitor.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluctl;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       instrdone;
    logic       illegal;
  } ctrl_t;

  typedef struct {
    string name;
    ctrl_t exp;
  } item_t;

  logic       clk, reset, Zero, MemReady;
  logic [5:0] Op, Funct;
  logic       IorD, MemWrite, IRWrite, PCEn, ALUSrcA, RegDst, MemtoReg, RegWrite, InstrDone, Illegal;
  logic [1:0] PCSrc, ALUSrcB;
  logic [3:0] ALUControl;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .InstrDone(InstrDone), .Illegal(Illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected control words, hand-derived from the state table.
  function automatic ctrl_t f_reset();
    ctrl_t c = '0;
    c.alusrcb = 2'b01; c.aluctl = 4'b0010;
    return c;
  endfunction
  function automatic ctrl_t f_fetch(logic mr);
    ctrl_t c = f_reset();
    c.irwrite = mr; c.pcen = mr;
    return c;
  endfunction
  function automatic ctrl_t f_decode(logic ill);
    ctrl_t c = '0;
    c.alusrcb = 2'b11; c.aluctl = 4'b0010; c.illegal = ill;
    return c;
  endfunction
  function automatic ctrl_t f_memadr();
    ctrl_t c = '0;
    c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluctl = 4'b0010;
    return c;
  endfunction
  function automatic ctrl_t f_memrd();
    ctrl_t c = '0;
    c.iord = 1'b1;
    return c;
  endfunction
  function automatic ctrl_t f_memwb();
    ctrl_t c = '0;
    c.memtoreg = 1'b1; c.regwrite = 1'b1; c.instrdone = 1'b1;
    return c;
  endfunction
  function automatic ctrl_t f_memwr(logic mr);
    ctrl_t c = '0;
    c.iord = 1'b1; c.memwrite = 1'b1; c.instrdone = mr;
    return c;
  endfunction
  function automatic ctrl_t f_exec(logic [3:0] alu);
    ctrl_t c = '0;
    c.alusrca = 1'b1; c.aluctl = alu;
    return c;
  endfunction
  function automatic ctrl_t f_aluwb();
    ctrl_t c = '0;
    c.regdst = 1'b1; c.regwrite = 1'b1; c.instrdone = 1'b1;
    return c;
  endfunction
  function automatic ctrl_t f_beqex(logic z);
    ctrl_t c = '0;
    c.alusrca = 1'b1; c.aluctl = 4'b0110; c.pcsrc = 2'b01; c.pcen = z; c.instrdone = 1'b1;
    return c;
  endfunction
  function automatic ctrl_t f_addiex();
    ctrl_t c = f_memadr();
    return c;
  endfunction
  function automatic ctrl_t f_addiwb();
    ctrl_t c = '0;
    c.regwrite = 1'b1; c.instrdone = 1'b1;
    return c;
  endfunction
  function automatic ctrl_t f_jex();
    ctrl_t c = '0;
    c.pcsrc = 2'b10; c.pcen = 1'b1; c.instrdone = 1'b1;
    return c;
  endfunction

  // One clock cycle of stimulus plus the control word the DUT must show in it.
  task automatic step(input string name, input ctrl_t e, input logic [5:0] op,
                      input logic [5:0] fn, input logic z, input logic mr, input logic rst);
    item_t it;
    @(posedge clk);
    #1;
    Op = op; Funct = fn; Zero = z; MemReady = mr; reset = rst;
    it.name = name;
    it.exp  = e;
    q.push_back(it);
  endtask

  task automatic run_rtype(input string name, input logic [5:0] fn, input logic [3:0] alu);
    step({name, "_fetch"}, f_fetch(1'b1), 6'b000000, fn, 1'b0, 1'b1, 1'b0);
    step({name, "_decode"}, f_decode(1'b0), 6'b000000, fn, 1'b0, 1'b1, 1'b0);
    step({name, "_execute"}, f_exec(alu), 6'b000000, fn, 1'b0, 1'b1, 1'b0);
    step({name, "_aluwb"}, f_aluwb(), 6'b000000, fn, 1'b0, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      ctrl_t act;
      it  = q.pop_front();
      act = {IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB, ALUControl,
             RegDst, MemtoReg, RegWrite, InstrDone, Illegal};
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: actual=%b required=%b (iord,memwr,irwr,pcen,pcsrc,srca,srcb,aluctl,regdst,memtoreg,regwr,done,illegal)",
                 it.name, act, it.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [5:0] fn_tab [5];
    logic [3:0] alu_tab[5];
    fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    alu_tab = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
    reset = 1'b1; Op = '0; Funct = '0; Zero = 1'b0; MemReady = 1'b0;

    // Strobes stay low under reset even with MemReady high in FETCH.
    step("reset", f_reset(), 6'b000000, 6'b000000, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 5; i++) run_rtype($sformatf("rtype%0d", i), fn_tab[i], alu_tab[i]);

    // ADDI with one FETCH stall cycle.
    step("addi_fetch_wait", f_fetch(1'b0), 6'b001000, 6'b0, 1'b0, 1'b0, 1'b0);
    step("addi_fetch", f_fetch(1'b1), 6'b001000, 6'b0, 1'b0, 1'b1, 1'b0);
    step("addi_decode", f_decode(1'b0), 6'b001000, 6'b0, 1'b0, 1'b1, 1'b0);
    step("addi_ex", f_addiex(), 6'b001000, 6'b0, 1'b0, 1'b1, 1'b0);
    step("addi_wb", f_addiwb(), 6'b001000, 6'b0, 1'b0, 1'b1, 1'b0);

    // LW: MemReady low (ignored) in DECODE/MEMADR, then two MEMRD wait cycles.
    step("lw_fetch", f_fetch(1'b1), 6'b100011, 6'b0, 1'b0, 1'b1, 1'b0);
    step("lw_decode", f_decode(1'b0), 6'b100011, 6'b0, 1'b0, 1'b0, 1'b0);
    step("lw_memadr", f_memadr(), 6'b100011, 6'b0, 1'b0, 1'b0, 1'b0);
    step("lw_memrd_w1", f_memrd(), 6'b100011, 6'b0, 1'b0, 1'b0, 1'b0);
    step("lw_memrd_w2", f_memrd(), 6'b100011, 6'b0, 1'b0, 1'b0, 1'b0);
    step("lw_memrd", f_memrd(), 6'b100011, 6'b0, 1'b0, 1'b1, 1'b0);
    step("lw_memwb", f_memwb(), 6'b100011, 6'b0, 1'b0, 1'b1, 1'b0);

    // SW with MemReady high: four cycles.
    step("sw_fetch", f_fetch(1'b1), 6'b101011, 6'b0, 1'b0, 1'b1, 1'b0);
    step("sw_decode", f_decode(1'b0), 6'b101011, 6'b0, 1'b0, 1'b1, 1'b0);
    step("sw_memadr", f_memadr(), 6'b101011, 6'b0, 1'b0, 1'b1, 1'b0);
    step("sw_memwr", f_memwr(1'b1), 6'b101011, 6'b0, 1'b0, 1'b1, 1'b0);

    // BEQ taken and not taken.
    step("beq1_fetch", f_fetch(1'b1), 6'b000100, 6'b0, 1'b1, 1'b1, 1'b0);
    step("beq1_decode", f_decode(1'b0), 6'b000100, 6'b0, 1'b1, 1'b1, 1'b0);
    step("beq1_ex", f_beqex(1'b1), 6'b000100, 6'b0, 1'b1, 1'b1, 1'b0);
    step("beq0_fetch", f_fetch(1'b1), 6'b000100, 6'b0, 1'b0, 1'b1, 1'b0);
    step("beq0_decode", f_decode(1'b0), 6'b000100, 6'b0, 1'b0, 1'b1, 1'b0);
    step("beq0_ex", f_beqex(1'b0), 6'b000100, 6'b0, 1'b0, 1'b1, 1'b0);

    // Illegal opcode and illegal R-type Funct.
    step("ill_op_fetch", f_fetch(1'b1), 6'b111111, 6'b0, 1'b0, 1'b1, 1'b0);
    step("ill_op_decode", f_decode(1'b1), 6'b111111, 6'b0, 1'b0, 1'b1, 1'b0);
    step("ill_fn_fetch", f_fetch(1'b1), 6'b000000, 6'b000001, 1'b0, 1'b1, 1'b0);
    step("ill_fn_decode", f_decode(1'b1), 6'b000000, 6'b000001, 1'b0, 1'b1, 1'b0);

    // J: accepted only with the jump macro.
    step("j_fetch", f_fetch(1'b1), 6'b000010, 6'b0, 1'b0, 1'b1, 1'b0);
`ifdef MIPS_JUMP_EN
    step("j_decode", f_decode(1'b0), 6'b000010, 6'b0, 1'b0, 1'b1, 1'b0);
    step("j_ex", f_jex(), 6'b000010, 6'b0, 1'b0, 1'b1, 1'b0);
`else
    step("j_decode_illegal", f_decode(1'b1), 6'b000010, 6'b0, 1'b0, 1'b1, 1'b0);
`endif

    // SW stalled in MEMWR, then reset mid-write.
    step("swr_fetch", f_fetch(1'b1), 6'b101011, 6'b0, 1'b0, 1'b1, 1'b0);
    step("swr_decode", f_decode(1'b0), 6'b101011, 6'b0, 1'b0, 1'b1, 1'b0);
    step("swr_memadr", f_memadr(), 6'b101011, 6'b0, 1'b0, 1'b1, 1'b0);
    step("swr_memwr_w1", f_memwr(1'b0), 6'b101011, 6'b0, 1'b0, 1'b0, 1'b0);
    step("swr_memwr_w2", f_memwr(1'b0), 6'b101011, 6'b0, 1'b0, 1'b0, 1'b0);
    step("swr_reset", f_reset(), 6'b101011, 6'b0, 1'b0, 1'b1, 1'b1);
    run_rtype("post_reset_add", 6'b100000, 4'b0010);

    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: actual=%0d pending required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multi-cycle sequencer for the MIPS datapath: decodes Op/Funct once per instruction, then steps the shared ALU, memory port, instruction register, PC and register file through fetch, decode, execute, memory and writeback states. It replaces the single-cycle control unit when the core runs on one unified memory and one ALU. Memory accesses stall on a ready handshake. Each instruction ends with a one-cycle completion pulse.

## Interface
- No parameters.
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high; forces state FETCH
- Op  in  6  instruction opcode field, from the instruction register
- Funct  in  6  R-type function field, from the instruction register
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completed the current read/write this cycle
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- PCEn  out  1  PC load = PCWrite | (Branch & Zero)
- PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- ALUControl  out  4  ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = ALUOut, 1 = memory data
- RegWrite  out  1  register file write strobe
- InstrDone  out  1  one-cycle pulse in the final state of each instruction
- Illegal  out  1  one-cycle pulse when DECODE rejects Op/Funct

## Operation
- Supported instructions: R-type ADD/SUB/AND/OR/SLT (Op 000000), LW 100011, SW 101011, BEQ 000100, ADDI 001000, and J 000010 when the jump macro is defined.
- Funct codes: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
- Moore FSM. Outputs decode from the state only, except the MemReady gating below.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ADD, PCSrc=00.
  - IRWrite=PCWrite=MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ADD.
  - Next state by Op: LW/SW → MEMADR; R-type → EXECUTE; BEQ → BEQEX; ADDI → ADDIEX; J → JEX.
  - Any other Op, or R-type with an unsupported Funct → FETCH, with Illegal=1. No datapath write occurs.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Goes to MEMRD (LW) or MEMWR (SW).
- MEMRD: IorD=1. Waits for MemReady, then goes to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, InstrDone=1. Goes to FETCH.
- MEMWR: IorD=1, MemWrite=1. Stays until MemReady=1; InstrDone=MemReady. Then goes to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct. Goes to ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, InstrDone=1. Goes to FETCH.
- BEQEX: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, Branch=1, InstrDone=1. Goes to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD. Goes to ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, InstrDone=1. Goes to FETCH.
- JEX: PCSrc=10, PCWrite=1, InstrDone=1. Goes to FETCH.
- Any unlisted strobe is 0 in every state. Unlisted mux selects are 0.

## Timing
- Reset (async assert, sync release at the next edge): state=FETCH.
  - While reset=1, every strobe is 0: IRWrite, PCEn, MemWrite, RegWrite, InstrDone, Illegal.
  - While reset=1, mux selects show FETCH values: ALUSrcB=01, ALUControl=0010, all other selects 0.
- Reset asserted mid-instruction: any pending write is dropped immediately; the FSM restarts at FETCH.
- Cycles per instruction with MemReady held at 1:
  - BEQ and J: 3
  - R-type, SW, ADDI: 4
  - LW: 5
  - Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- In MEMWR, MemWrite stays asserted during the wait. Memory treats the write as committed on the MemReady=1 cycle.
- MemReady is ignored outside FETCH, MEMRD and MEMWR.
- In BEQEX, PCEn=Zero in the same cycle.

## Configuration
- MIPS_JUMP_EN defined: state JEX exists, Op 000010 is accepted, PCSrc=10 is reachable.
- MIPS_JUMP_EN undefined: JEX is absent, Op 000010 takes the Illegal path, PCSrc never equals 10.

## Structure
- Package mips_ctrl_pkg holds:
  - opcode and Funct constants
  - ALUControl encodings
  - ALUSrcB and PCSrc encodings
  - the state enum
- Sub-module alu_decoder: combinational, Funct → ALUControl plus a valid flag. DECODE uses the flag for the Illegal check.

## Test plan
- ADD (Op 000000, Funct 100000), MemReady=1: states FETCH, DECODE, EXECUTE, ALUWB. ALUControl=0010 in EXECUTE; RegWrite=1 and RegDst=1 in ALUWB; InstrDone pulses on cycle 4.
- LW with MemReady low for 2 cycles in MEMRD: 7 cycles total. RegWrite=1 with MemtoReg=1 only in MEMWB; IorD=1 across all MEMRD cycles.
- BEQ run twice, once with Zero=1 and once with Zero=0: ALUControl=0110 and PCSrc=01 in BEQEX both times. PCEn=1 only in the Zero=1 run; 3 cycles each.
- Op 111111: Illegal pulses in DECODE, next state is FETCH, no RegWrite or MemWrite. Repeat with Op 000000, Funct 000001.
- Reset asserted during SW's MEMWR: MemWrite drops to 0 asynchronously. After release, FETCH has IorD=0 and ALUSrcB=01.
- Op 000010 with MIPS_JUMP_EN defined: 3 cycles, PCSrc=10 and PCEn=1 in JEX. With the macro undefined: Illegal pulses instead.
